// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpram_pkg
// Description : Shared types and constants for the dual-port RAM with clear
//               engine (dpram_clr and dpram_clear_fsm).
//               - clr_state_t : clear engine state (IDLE / CLEAR)
//               - RDW_OLD/NEW : read-during-write mode selectors
// Revision    : 1.0 - initial release
// ============================================================================
package dpram_pkg;

    // Clear engine state, explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Read-during-write result selection.
    localparam int RDW_OLD = 0;   // read returns pre-write contents
    localparam int RDW_NEW = 1;   // read returns the word being stored

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/dpram_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dpram_clear_fsm
// Description : Clear engine for dpram_clr. Sweeps every RAM address once,
//               one address per clock, after reset release (optional) or on
//               a clear request from IDLE.
// Ports       : clock      - rising-edge clock
//               reset_n    - asynchronous active-low reset
//               clear_req  - start a sweep (ignored while sweeping)
//               busy       - high while the sweep runs
//               sweep_we   - write strobe for the sweep word
//               sweep_addr - address being initialised this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_clear_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr
);

    // One spare counter bit so the terminal compare never relies on wrap.
    localparam logic [ADDR_WIDTH:0] c_last_addr = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

    clr_state_t          r_state;
    clr_state_t          w_state_next;
    logic [ADDR_WIDTH:0] r_count;
    logic [ADDR_WIDTH:0] w_count_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_next = CLEAR;
                    w_count_next = '0;
                end
            end
            CLEAR: begin
                // Requests during a sweep are deliberately not looked at.
                if (r_count == c_last_addr) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
            end
        endcase
    end

    assign busy       = (r_state == CLEAR);
    assign sweep_we   = (r_state == CLEAR);
    assign sweep_addr = r_count[ADDR_WIDTH-1:0];

endmodule : dpram_clear_fsm
`default_nettype wire

// File: rtl/dpram_clr.sv
`default_nettype none
// ============================================================================
// Module      : dpram_clr
// Description : True dual-port synchronous RAM with built-in clear engine.
//               Port A (CPU side) and port B (video side) read every cycle and
//               may write simultaneously; a same-address double write keeps
//               port A's data and flags a collision. While the clear engine
//               runs, user writes are dropped and both read ports return 0.
// Ports       : clock, reset_n           - clock / async active-low reset
//               clear_req, busy          - clear engine request / status
//               address_a, data_a, wren_a, q_a - port A
//               address_b, data_b, wren_b, q_b - port B
//               collision                - registered same-address write flag
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_clr
    import dpram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 9,
    parameter int                    RDW_MODE       = 0,
    parameter int                    OUT_REG        = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  wren_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wren_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  collision
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic                  w_sweep_we;
    logic [ADDR_WIDTH-1:0] w_sweep_addr;

    dpram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .busy       (busy),
        .sweep_we   (w_sweep_we),
        .sweep_addr (w_sweep_addr)
    );

    // ------------------------------------------------------------------
    // Write path: the sweep borrows port A; port B is silenced while busy
    // and also loses a same-address race against port A.
    // ------------------------------------------------------------------
    logic                  w_same_addr;
    logic                  w_wa_en;
    logic [ADDR_WIDTH-1:0] w_wa_addr;
    logic [DATA_WIDTH-1:0] w_wa_data;
    logic                  w_wb_en;

    assign w_same_addr = (address_a == address_b);
    assign w_wa_en     = busy ? w_sweep_we   : wren_a;
    assign w_wa_addr   = busy ? w_sweep_addr : address_a;
    assign w_wa_data   = busy ? INIT_VALUE   : data_a;
    assign w_wb_en     = !busy && wren_b && !(wren_a && w_same_addr);

    // Storage carries no reset; only the sweep initialises it.
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    always_ff @(posedge clock) begin
        if (w_wa_en) r_mem[w_wa_addr] <= w_wa_data;
        if (w_wb_en) r_mem[address_b] <= data_b;
    end

    // ------------------------------------------------------------------
    // Read path. In new-data mode the port A check comes last so that the
    // winning (stored) word is what the reader sees.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd_a_next;
    logic [DATA_WIDTH-1:0] w_rd_b_next;

    always_comb begin
        w_rd_a_next = r_mem[address_a];
        w_rd_b_next = r_mem[address_b];
        if (RDW_MODE == RDW_NEW) begin
            if (w_wb_en && (address_b == address_a)) w_rd_a_next = data_b;
            if (w_wa_en && (w_wa_addr == address_a)) w_rd_a_next = w_wa_data;
            if (w_wb_en)                              w_rd_b_next = data_b;
            if (w_wa_en && (w_wa_addr == address_b)) w_rd_b_next = w_wa_data;
        end
        if (busy) begin
            w_rd_a_next = '0;
            w_rd_b_next = '0;
        end
    end

    logic [DATA_WIDTH-1:0] r_rd_a;
    logic [DATA_WIDTH-1:0] r_rd_b;
    logic                  r_collision;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_a      <= '0;
            r_rd_b      <= '0;
            r_collision <= 1'b0;
        end else begin
            r_rd_a      <= w_rd_a_next;
            r_rd_b      <= w_rd_b_next;
            r_collision <= !busy && wren_a && wren_b && w_same_addr;
        end
    end

    // Masking with busy makes the outputs read 0 from the very first busy
    // cycle rather than one cycle later.
    logic [DATA_WIDTH-1:0] w_q_a_gated;
    logic [DATA_WIDTH-1:0] w_q_b_gated;

    assign w_q_a_gated = busy ? '0 : r_rd_a;
    assign w_q_b_gated = busy ? '0 : r_rd_b;
    assign collision   = r_collision;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_pipe_a;
            logic [DATA_WIDTH-1:0] r_pipe_b;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipe_a <= '0;
                    r_pipe_b <= '0;
                end else begin
                    r_pipe_a <= w_q_a_gated;
                    r_pipe_b <= w_q_b_gated;
                end
            end

            assign q_a = r_pipe_a;
            assign q_b = r_pipe_b;
        end else begin : g_no_out_reg
            assign q_a = w_q_a_gated;
            assign q_b = w_q_b_gated;
        end
    endgenerate

endmodule : dpram_clr
`default_nettype wire

// File: tb/tb_dpram_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_clr
// Description : Self-checking bench for dpram_clr. Two instances share one
//               stimulus stream: u_old (old-data reads, no output register)
//               and u_new (new-data reads, output register). A behavioural
//               memory model predicts busy, q_a/q_b and collision each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_clr;

    localparam int         AW    = 4;
    localparam int         DW    = 8;
    localparam int         DEPTH = 16;
    localparam logic [7:0] INIT  = 8'hA5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          clear_req = 1'b0;
    logic [AW-1:0] address_a = '0;
    logic [DW-1:0] data_a = '0;
    logic          wren_a = 1'b0;
    logic [AW-1:0] address_b = '0;
    logic [DW-1:0] data_b = '0;
    logic          wren_b = 1'b0;

    logic          busy0, busy1, col0, col1;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;

    always #5 clock = ~clock;

    dpram_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0),
        .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)
    ) u_old (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a0),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b0),
        .collision(col0)
    );

    dpram_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1),
        .INIT_VALUE(INIT), .CLEAR_ON_RESET(1'b1)
    ) u_new (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(busy1),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a1),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b1),
        .collision(col1)
    );

    // Reference model state
    logic [7:0] m_mem [DEPTH];
    int         clr_left;      // sweep cycles still to run (0 = idle)
    int         sweep_pos;
    logic [7:0] s1_a, s1_b;    // first read stage of the registered-output copy
    logic [7:0] e0_a, e0_b, e1_a, e1_b;
    logic       e_col;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        clr_left  = DEPTH;
        sweep_pos = 0;
        s1_a = 8'h00; s1_b = 8'h00;
        e0_a = 8'h00; e0_b = 8'h00; e1_a = 8'h00; e1_b = 8'h00;
        e_col = 1'b0;
    endtask

    // One clock: update the model from the inputs sampled at the edge, then
    // compare every output 1 time unit later.
    task automatic cycle();
        logic       was_busy;
        logic [7:0] old_a, old_b, new_a, new_b;
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            was_busy = (clr_left > 0);
            if (was_busy) begin
                m_mem[sweep_pos] = INIT;
                sweep_pos++;
                clr_left--;
                old_a = 8'h00; old_b = 8'h00; new_a = 8'h00; new_b = 8'h00;
                e_col = 1'b0;
            end else begin
                old_a = m_mem[address_a];
                old_b = m_mem[address_b];
                // B first so that A overwrites it on a shared address.
                if (wren_b) m_mem[address_b] = data_b;
                if (wren_a) m_mem[address_a] = data_a;
                new_a = m_mem[address_a];
                new_b = m_mem[address_b];
                e_col = wren_a && wren_b && (address_a == address_b);
                if (clear_req) begin
                    clr_left  = DEPTH;
                    sweep_pos = 0;
                end
            end
            // Registered-output copy lags one more cycle.
            e1_a = was_busy ? 8'h00 : s1_a;
            e1_b = was_busy ? 8'h00 : s1_b;
            s1_a = new_a;
            s1_b = new_b;
            // Single-stage copy goes to 0 as soon as busy is up.
            e0_a = (clr_left > 0) ? 8'h00 : old_a;
            e0_b = (clr_left > 0) ? 8'h00 : old_b;
        end
        #1;
        chk("busy_old", {7'd0, busy0}, {7'd0, (clr_left > 0)});
        chk("busy_new", {7'd0, busy1}, {7'd0, (clr_left > 0)});
        chk("q_a_old", q_a0, e0_a);
        chk("q_b_old", q_b0, e0_b);
        chk("q_a_new", q_a1, e1_a);
        chk("q_b_new", q_b1, e1_b);
        chk("col_old", {7'd0, col0}, {7'd0, e_col});
        chk("col_new", {7'd0, col1}, {7'd0, e_col});
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0; wren_a = 1'b0; wren_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        model_reset();

        // Reset and power-up sweep
        #1 reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        repeat (DEPTH) cycle();
        chk("busy_after_sweep", {7'd0, busy0}, 8'h00);

        // Every address holds INIT after the sweep
        for (int i = 0; i < DEPTH; i++) begin
            address_a = AW'(i); address_b = AW'(DEPTH - 1 - i);
            cycle();
            chk("init_read", q_a0, INIT);
        end

        // Independent writes on both ports
        address_a = 4'd3; data_a = 8'h12; wren_a = 1'b1;
        address_b = 4'd7; data_b = 8'h34; wren_b = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        chk("rd_3", q_a0, 8'h12);
        chk("rd_7", q_b0, 8'h34);
        chk("no_col", {7'd0, col0}, 8'h00);

        // Same-address collision
        address_a = 4'd5; data_a = 8'h11; wren_a = 1'b1;
        address_b = 4'd5; data_b = 8'h22; wren_b = 1'b1;
        cycle();
        chk("col_pulse", {7'd0, col0}, 8'h01);
        idle_inputs();
        cycle();
        chk("col_drop", {7'd0, col0}, 8'h00);
        chk("rd_5_winner", q_a0, 8'h11);

        // Read during write
        address_a = 4'd9; data_a = 8'h40; wren_a = 1'b1;
        cycle();
        data_a = 8'h41; address_b = 4'd9;
        cycle();
        chk("rdw_old", q_b0, 8'h40);
        idle_inputs();
        cycle();
        chk("rdw_new", q_b1, 8'h41);

        // Output register latency
        address_a = 4'd2; data_a = 8'h77; wren_a = 1'b1;
        cycle();
        idle_inputs();
        address_a = 4'd0;
        cycle();
        address_a = 4'd2;
        cycle();
        chk("outreg_lat1", q_a1, 8'h00 | m_mem[4'd0]);
        cycle();
        chk("outreg_lat2", q_a1, 8'h77);

        // Random traffic with occasional clear requests
        for (int n = 0; n < 200; n++) begin
            address_a = AW'($urandom_range(DEPTH - 1));
            address_b = AW'($urandom_range(DEPTH - 1));
            data_a    = DW'($urandom);
            data_b    = DW'($urandom);
            wren_a    = ($urandom_range(1) == 1);
            wren_b    = ($urandom_range(1) == 1);
            clear_req = ($urandom_range(39) == 0);
            cycle();
        end
        idle_inputs();
        repeat (DEPTH + 2) cycle();

        // Clear mid-traffic, writes during busy, reset at sweep address 8
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int n = 0; n < 8; n++) begin
            wren_a = 1'b1; address_a = AW'($urandom_range(DEPTH - 1)); data_a = DW'($urandom);
            cycle();
        end
        reset_n = 1'b0;
        wren_a = 1'b0;
        cycle();
        chk("busy_in_reset", {7'd0, busy0}, 8'h01);
        reset_n = 1'b1;
        for (int n = 0; n < DEPTH; n++) begin
            wren_a = ($urandom_range(1) == 1);
            address_a = AW'($urandom_range(DEPTH - 1));
            data_a = DW'($urandom);
            cycle();
        end
        idle_inputs();
        chk("busy_after_restart", {7'd0, busy0}, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            address_a = AW'(i); address_b = AW'(i);
            cycle();
            chk("reinit_read", q_b0, INIT);
        end
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop so a hung run still ends with a report.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_dpram_clr
`default_nettype wire
